// File: rtl/bcd_seg_driver.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding
// registered active-low 7-segment patterns with leading-zero blanking and overflow dashes.
module bcd_seg_driver #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 3,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [63:0] max_value(input int d);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < d; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_value(DIGITS);

    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state;
    logic [WIDTH-1:0]      shreg;
    logic [4*DIGITS-1:0]   scratch;
    logic [CW-1:0]         cnt;
    logic                  ovf_next;

    logic [4*DIGITS-1:0]   adjusted;
    logic [4*DIGITS-1:0]   scratch_next;
    logic [7*DIGITS-1:0]   seg_next;

    // One double-dabble step; the top scratch bit falls off so the result wraps mod 10^DIGITS.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        scratch_next = {adjusted[4*DIGITS-2:0], shreg[WIDTH-1]};
    end

    // Walk from the most significant digit so "all higher digits zero" is a running flag.
    always_comb begin : encode_blk
        logic       lead;
        logic [3:0] digit;
        lead     = 1'b1;
        digit    = 4'd0;
        seg_next = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            digit = scratch_next[4*i +: 4];
            if (ovf_next)
                seg_next[7*i +: 7] = 7'b0111111;
            else if (BLANK_ZEROS && (i > 0) && lead && (digit == 4'd0))
                seg_next[7*i +: 7] = 7'b1111111;
            else
                seg_next[7*i +: 7] = encode(digit);
            lead = lead && (digit == 4'd0);
        end
    end

    // start/busy: a request is taken on any rising edge with start=1 while busy=0;
    // start seen while busy is dropped, never queued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_next <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            seg      <= '1;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= bin;
                        scratch  <= '0;
                        cnt      <= CW'(WIDTH);
                        ovf_next <= (64'(bin) > MAX_VAL);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_next;
                    shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd      <= scratch_next;
                        seg      <= seg_next;
                        overflow <= ovf_next;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/bcd_seg_driver.md
# bcd_seg_driver

Parametrised sequential binary-to-7-segment display driver for the Fibonacci processor board. It takes a WIDTH-bit unsigned value on a start strobe and converts it to DIGITS BCD digits with an iterative double-dabble engine, one bit per clock. It then registers active-low 7-segment patterns with optional leading-zero blanking and overflow indication. It replaces the fixed 8-bit/3-digit combinational converter and encoder path between the datapath output and the board displays.

## Interface

- WIDTH, 8, bit width of the binary input (2..32)
- DIGITS, 3, number of decimal digits driven (1..10)
- BLANK_ZEROS, 1, 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all digits
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous, active-low; one clock, no other reset
- start  input  1  conversion request, sampled only in IDLE
- bin  input  WIDTH  unsigned value, sampled on the edge that accepts start
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when new results are valid
- bcd  output  4*DIGITS  registered BCD result; digit 0 (units) in bits [3:0]
- seg  output  7*DIGITS  registered active-low segments; digit i in bits [7i+6:7i], bit order g..a
- overflow  output  1  registered; high when the last converted value exceeds 10^DIGITS-1

## Operation

- States: IDLE, SHIFT. Reset enters IDLE.
- IDLE with start=1: latch bin into the shift register, clear the BCD scratch, and load the iteration counter with WIDTH. Compute ovf_next = (bin > 10^DIGITS-1) from an elaborated constant. Go to SHIFT.
- IDLE with start=0: hold. All outputs hold their last values.
- SHIFT, once per cycle:
  - Add 3 to every scratch digit ≥ 5.
  - Shift {scratch, shreg} left by 1.
  - Decrement the counter.
  - The bit shifted out of the top digit is discarded, so the scratch holds the value mod 10^DIGITS.
- SHIFT when the counter reaches 1 (the last iteration):
  - Write the final scratch to bcd.
  - Write ovf_next to overflow.
  - Write the encoded patterns to seg.
  - Assert done for the next cycle and return to IDLE.
- Segment encoding, active-low, per digit:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Any other value encodes to blank (1111111).
- Blanking (BLANK_ZEROS=1): digit i>0 shows 1111111 when it and all higher digits are zero. Digit 0 always shows its value.
- Overflow: every seg digit shows a dash (0111111). bcd still carries the value mod 10^DIGITS.
- start while busy is ignored. It is not queued.

## Timing

- start accepted at edge N. busy is high from after edge N until after edge N+WIDTH, i.e. for exactly WIDTH cycles.
- bcd, seg, overflow update at edge N+WIDTH. done is high for the single cycle following that edge.
- Back-to-back: start held high during the done cycle is accepted (the FSM is in IDLE). Throughput is one conversion per WIDTH+1 cycles.
- Reset values: busy=0, done=0, overflow=0, bcd=0, all seg digits 1111111. FSM in IDLE, counter 0.
- Reset asserted mid-conversion aborts immediately. There is no done pulse, and the outputs take their reset values.
- bin may change freely after the accepting edge.
- Outputs are glitch-free: all are driven directly from flops.

## Test plan

- Defaults, reset then start with bin=0 → after 8 cycles done=1, bcd=0x000. seg digit0=1000000, digits 1,2=1111111.
- Defaults, bin=255 → busy high exactly 8 cycles; done at N+8. bcd=0x255, seg = 0100100 / 0010010 / 0010010 (digits 2/1/0), overflow=0.
- Defaults, bin=7, then BLANK_ZEROS=0 rebuild → blanking on: digit0=1111000, digits 1,2 blank. Blanking off: digits 1,2=1000000.
- WIDTH=10, DIGITS=3, bin=1023 → overflow=1, bcd=0x023, all digits 0111111. Next conversion of bin=999: overflow=0, bcd=0x999.
- Defaults, start with bin=42; pulse start with bin=99 at N+3; assert rst low at N+5 on a second run → first run: second start ignored, result 0x042 at N+8. Second run: busy drops asynchronously, no done, seg all blank, bcd=0.
- Defaults, start held high continuously with bin=1,2,3 changing at each acceptance → done every 9 cycles with bcd 0x001, 0x002, 0x003 in order.
